// File: rtl/carfield_pkg.sv
// carfield_pkg
// Shared definitions for the Carfield domain boot sequencer: default
// geometry, the sequencer state type and the error-stage encoding.
// No ports (package).
package carfield_pkg;

  localparam int unsigned DefaultNumDomains    = 4;
  localparam int unsigned DefaultCntWidth      = 16;
  localparam int unsigned DefaultTimeoutCycles = 1024;

  // err_dom_o value reporting a HyperBus PHY timeout: one past the last
  // domain index, so it can never be confused with a domain failure.
  localparam int unsigned PhyErrIdx = DefaultNumDomains;

  typedef enum logic [2:0] {
    SEQ_SAMPLE,
    SEQ_WAIT_PHY,
    SEQ_CLK_EN,
    SEQ_RST_REL,
    SEQ_DONE,
    SEQ_ERROR,
    SEQ_RESTART
  } dom_seq_state_e;

endpackage

// File: rtl/carfield_seq_cnt.sv
// carfield_seq_cnt
// Loadable up/down counter shared by the settle-delay and timeout phases.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clr_i          synchronous clear to zero
//   load_i         synchronous load of load_val_i (wins over clr_i)
//   load_val_i     load value
//   en_i           count enable
//   down_i         1 = count down (delay), 0 = count up (timeout)
//   tc_o           terminal count: 1 when counting down, TermUp when up
module carfield_seq_cnt #(
  parameter int unsigned CntWidth = 16,
  parameter int unsigned TermUp   = 1023
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic [CntWidth-1:0] load_val_i,
  input  logic                en_i,
  input  logic                down_i,
  output logic                tc_o
);

  logic [CntWidth-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= down_i ? cnt_q - 1'b1 : cnt_q + 1'b1;
    end
  end

  // Down-count ends at 1 (not 0) so a load of N spends exactly N cycles.
  assign tc_o = down_i ? (cnt_q == CntWidth'(1)) : (cnt_q == CntWidth'(TermUp));

endmodule

// File: rtl/carfield_dom_boot_seq.sv
// carfield_dom_boot_seq
// Power-on/restart sequencer for the Carfield clock/reset domains. Latches
// the boot straps, waits for the HyperBus PHY, then enables each domain's
// clock and releases its reset in index order with a settle delay and an
// acknowledge timeout.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   test_mode_i        DFT bypass: forces all clock enables / resets released
//   boot_mode_i        boot-mode straps, latched in SAMPLE -> boot_mode_o
//   cfg_delay_i        clock-enable to reset-release settle delay (min 1)
//   hyp_phy_ready_i    HyperBus PHY calibrated
//   dom_ack_i          per-domain reset synchroniser released
//   sw_restart_i       restart request, honoured in DONE / ERROR only
//   dom_clk_en_o       per-domain clock enable
//   dom_rst_no         per-domain reset, active-low
//   done_o, err_o      sequence complete / timeout occurred
//   err_dom_o          failing stage (NumDomains = PHY timeout)
module carfield_dom_boot_seq
  import carfield_pkg::*;
#(
  parameter int unsigned NumDomains    = DefaultNumDomains,
  parameter int unsigned CntWidth      = DefaultCntWidth,
  parameter int unsigned TimeoutCycles = DefaultTimeoutCycles,
  localparam int unsigned IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1,
  localparam int unsigned ErrW = $clog2(NumDomains + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  test_mode_i,
  input  logic [1:0]            boot_mode_i,
  input  logic [CntWidth-1:0]   cfg_delay_i,
  input  logic                  hyp_phy_ready_i,
  input  logic [NumDomains-1:0] dom_ack_i,
  input  logic                  sw_restart_i,
  output logic [NumDomains-1:0] dom_clk_en_o,
  output logic [NumDomains-1:0] dom_rst_no,
  output logic [1:0]            boot_mode_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ErrW-1:0]       err_dom_o
);

  localparam logic [IdxW-1:0] LastIdx    = IdxW'(NumDomains - 1);
  localparam logic [ErrW-1:0] PhyErrCode = ErrW'(NumDomains);

  dom_seq_state_e        state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NumDomains-1:0] clk_en_q, clk_en_d;
  logic [NumDomains-1:0] rst_n_q, rst_n_d;
  logic [1:0]            boot_q, boot_d;
  logic [CntWidth-1:0]   delay_q, delay_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [ErrW-1:0]       err_dom_q, err_dom_d;

  logic cnt_clr, cnt_load, cnt_en, cnt_down, cnt_tc;

  carfield_seq_cnt #(
    .CntWidth (CntWidth),
    .TermUp   (TimeoutCycles - 1)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (delay_q),
    .en_i       (cnt_en),
    .down_i     (cnt_down),
    .tc_o       (cnt_tc)
  );

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    clk_en_d  = clk_en_q;
    rst_n_d   = rst_n_q;
    boot_d    = boot_q;
    delay_d   = delay_q;
    done_d    = done_q;
    err_d     = err_q;
    err_dom_d = err_dom_q;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_down  = 1'b0;

    unique case (state_q)
      SEQ_SAMPLE: begin
        boot_d  = boot_mode_i;
        delay_d = (cfg_delay_i == '0) ? CntWidth'(1) : cfg_delay_i;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_clr = 1'b1;
        state_d = SEQ_WAIT_PHY;
      end
      SEQ_WAIT_PHY: begin
        // Ready is tested before the timeout so it wins a tie.
        if (hyp_phy_ready_i) begin
          idx_d       = '0;
          clk_en_d[0] = 1'b1;
          cnt_load    = 1'b1;
          state_d     = SEQ_CLK_EN;
        end else if (cnt_tc) begin
          err_d     = 1'b1;
          err_dom_d = PhyErrCode;
          state_d   = SEQ_ERROR;
        end else begin
          cnt_en = 1'b1;
        end
      end
      SEQ_CLK_EN: begin
        cnt_down = 1'b1;
        if (cnt_tc) begin
          rst_n_d[idx_q] = 1'b1;
          cnt_clr        = 1'b1;
          state_d        = SEQ_RST_REL;
        end else begin
          cnt_en = 1'b1;
        end
      end
      SEQ_RST_REL: begin
        // Ack wins over a simultaneous timeout.
        if (dom_ack_i[idx_q]) begin
          if (idx_q == LastIdx) begin
            done_d  = 1'b1;
            state_d = SEQ_DONE;
          end else begin
            idx_d           = idx_q + 1'b1;
            clk_en_d[idx_d] = 1'b1;
            cnt_load        = 1'b1;
            state_d         = SEQ_CLK_EN;
          end
        end else if (cnt_tc) begin
          err_d     = 1'b1;
          err_dom_d = ErrW'(idx_q);
          state_d   = SEQ_ERROR;
        end else begin
          cnt_en = 1'b1;
        end
      end
      SEQ_DONE, SEQ_ERROR: begin
        if (sw_restart_i) begin
          rst_n_d  = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
          cnt_load = 1'b1;
          state_d  = SEQ_RESTART;
        end
      end
      SEQ_RESTART: begin
        // Resets stay asserted for the latched delay with clocks running,
        // then clocks are gated before the next boot.
        cnt_down = 1'b1;
        if (cnt_tc) begin
          clk_en_d = '0;
          state_d  = SEQ_SAMPLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = SEQ_SAMPLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SEQ_SAMPLE;
      idx_q     <= '0;
      clk_en_q  <= '0;
      rst_n_q   <= '0;
      boot_q    <= '0;
      delay_q   <= CntWidth'(1);
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_dom_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      clk_en_q  <= clk_en_d;
      rst_n_q   <= rst_n_d;
      boot_q    <= boot_d;
      delay_q   <= delay_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_dom_q <= err_dom_d;
    end
  end

  // DFT bypass sits after the registers so the FSM keeps its own state.
  assign dom_clk_en_o = test_mode_i ? '1 : clk_en_q;
  assign dom_rst_no   = test_mode_i ? '1 : rst_n_q;
  assign boot_mode_o  = boot_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_dom_o    = err_dom_q;

endmodule
